mem_read_arbiter: RTL and testbench

//  Shares the single AXI read port to memory between the i_cache (port 0) and the d_cache (port 1).

---
 rtl/mem_read_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//   Shares one AXI read port to memory between the i_cache (port 0) and the
//   d_cache (port 1). It grants one refill burst at a time and breaks ties
//   round-robin. It forwards the granted AR request, routes each returned R
//   beat to the owner, and releases the port after the counted last beat.
//   The write channels are not part of this block.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   s0_ar*, s0_r*        i_cache read address / read data (slave side)
//   s1_ar*, s1_r*        d_cache read address / read data (slave side)
//   m_ar*, m_r*          memory read address / read data (master side)
//   busy                 1 while in GRANT or DATA
//   owner                port of the current or most recent grant
//   proto_err            sticky; set by an R beat arriving outside DATA
module mem_read_arbiter #(
    parameter int unsigned CNT_WIDTH  = 5,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // i_cache
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [CNT_WIDTH-1:0]  s0_arlen,
    input  logic [ID_WIDTH-1:0]   s0_arid,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    // d_cache
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [CNT_WIDTH-1:0]  s1_arlen,
    input  logic [ID_WIDTH-1:0]   s1_arid,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    // memory
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [CNT_WIDTH-1:0]  m_arlen,
    output logic [ID_WIDTH-1:0]   m_arid,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    // status
    output logic                  busy,
    output logic                  owner,
    output logic                  proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DATA  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [CNT_WIDTH-1:0]  len;
        logic [ID_WIDTH-1:0]   id;
    } ar_req_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic                 last_grant_q, last_grant_d;
    logic                 proto_err_q, proto_err_d;
    ar_req_t              req_q, req_d;
    logic                 winner;
    logic                 owner_rready;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            proto_err_q  <= 1'b0;
            req_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            proto_err_q  <= proto_err_d;
            req_q        <= req_d;
        end
    end

    // Next-state, arbitration and channel steering
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        req_d        = req_q;
        proto_err_d  = proto_err_q | (m_rvalid && (state_q != ST_DATA));
        winner       = 1'b0;
        owner_rready = owner_q ? s1_rready : s0_rready;
        s0_arready   = 1'b0;
        s1_arready   = 1'b0;
        s0_rvalid    = 1'b0;
        s1_rvalid    = 1'b0;
        // Outside DATA stray beats are drained and dropped
        m_rready     = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    // Tie goes to the port that did not win last time
                    winner = (s0_arvalid && s1_arvalid) ? ~last_grant_q : s1_arvalid;
                    owner_d      = winner;
                    last_grant_d = winner;
                    if (winner) begin
                        req_d.addr = s1_araddr;
                        req_d.len  = s1_arlen;
                        req_d.id   = s1_arid;
                    end else begin
                        req_d.addr = s0_araddr;
                        req_d.len  = s0_arlen;
                        req_d.id   = s0_arid;
                    end
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (owner_q) s1_arready = m_arready;
                else         s0_arready = m_arready;
                if (m_arready) begin
                    // A zero length still moves one beat
                    cnt_d   = (req_q.len == '0) ? CNT_WIDTH'(1) : req_q.len;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (owner_q) s1_rvalid = m_rvalid;
                else         s0_rvalid = m_rvalid;
                m_rready = owner_rready;
                // Burst end is decided by the count; RLAST is not consulted
                if (m_rvalid && owner_rready) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                    if (cnt_q <= CNT_WIDTH'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign m_arvalid = (state_q == ST_GRANT);
    assign m_araddr  = req_q.addr;
    assign m_arlen   = req_q.len;
    assign m_arid    = req_q.id;
    assign s0_rdata  = m_rdata;
    assign s1_rdata  = m_rdata;
    assign busy      = (state_q != ST_IDLE);
    assign owner     = owner_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter.
module tb_mem_read_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] s0_araddr, s1_araddr, m_araddr;
    logic [4:0]  s0_arlen, s1_arlen, m_arlen;
    logic [3:0]  s0_arid, s1_arid, m_arid;
    logic        s0_arvalid, s1_arvalid, m_arvalid;
    logic        s0_arready, s1_arready, m_arready;
    logic [31:0] s0_rdata, s1_rdata, m_rdata;
    logic        s0_rvalid, s1_rvalid, m_rvalid;
    logic        s0_rready, s1_rready, m_rready;
    logic        busy, owner, proto_err;

    int total = 0;
    int bad   = 0;

    mem_read_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s0_araddr  (s0_araddr),
        .s0_arlen   (s0_arlen),
        .s0_arid    (s0_arid),
        .s0_arvalid (s0_arvalid),
        .s0_arready (s0_arready),
        .s0_rdata   (s0_rdata),
        .s0_rvalid  (s0_rvalid),
        .s0_rready  (s0_rready),
        .s1_araddr  (s1_araddr),
        .s1_arlen   (s1_arlen),
        .s1_arid    (s1_arid),
        .s1_arvalid (s1_arvalid),
        .s1_arready (s1_arready),
        .s1_rdata   (s1_rdata),
        .s1_rvalid  (s1_rvalid),
        .s1_rready  (s1_rready),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_arid     (m_arid),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rdata    (m_rdata),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .busy       (busy),
        .owner      (owner),
        .proto_err  (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Called one step after the edge that entered GRANT
    task automatic ar_accept(input logic own, input logic [31:0] a,
                             input logic [4:0] l, input logic [3:0] id);
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_owner", 32'(owner), 32'(own));
        chk("grant_arvalid", 32'(m_arvalid), 32'd1);
        chk("grant_araddr", m_araddr, a);
        chk("grant_arlen", 32'(m_arlen), 32'(l));
        chk("grant_arid", 32'(m_arid), 32'(id));
        m_arready = 1'b1;
        #1;
        chk("s0_arready", 32'(s0_arready), 32'(!own));
        chk("s1_arready", 32'(s1_arready), 32'(own));
        tick;
        m_arready = 1'b0;
        #1;
        chk("data_arvalid", 32'(m_arvalid), 32'd0);
        chk("data_busy", 32'(busy), 32'd1);
    endtask

    // n accepted beats to port p, one per cycle
    task automatic beats(input logic p, input int n);
        for (int i = 0; i < n; i++) begin
            m_rvalid  = 1'b1;
            m_rdata   = 32'hD000_0000 + 32'(i);
            s0_rready = 1'b1;
            s1_rready = 1'b1;
            #1;
            chk("own_rvalid", 32'(p ? s1_rvalid : s0_rvalid), 32'd1);
            chk("other_rvalid", 32'(p ? s0_rvalid : s1_rvalid), 32'd0);
            chk("own_rdata", p ? s1_rdata : s0_rdata, 32'hD000_0000 + 32'(i));
            tick;
        end
        m_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        s0_araddr = '0; s0_arlen = '0; s0_arid = '0; s0_arvalid = 1'b0; s0_rready = 1'b1;
        s1_araddr = '0; s1_arlen = '0; s1_arid = '0; s1_arvalid = 1'b0; s1_rready = 1'b1;
        m_arready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
        tick;
        tick;
        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_arvalid", 32'(m_arvalid), 32'd0);
        chk("rst_s0_arready", 32'(s0_arready), 32'd0);
        chk("rst_s1_arready", 32'(s1_arready), 32'd0);
        chk("rst_rready", 32'(m_rready), 32'd1);
        chk("rst_s0_rvalid", 32'(s0_rvalid), 32'd0);

        // 1: lone s1 request, memory accepts after two GRANT cycles
        rst_n = 1'b1;
        s1_araddr = 32'h0000_0100; s1_arlen = 5'd4; s1_arid = 4'd3; s1_arvalid = 1'b1;
        tick;
        chk("t1_s1_arready_wait0", 32'(s1_arready), 32'd0);
        tick;
        chk("t1_s1_arready_wait1", 32'(s1_arready), 32'd0);
        ar_accept(1'b1, 32'h0000_0100, 5'd4, 4'd3);
        s1_arvalid = 1'b0;
        beats(1'b1, 3);
        chk("t1_busy_before_last", 32'(busy), 32'd1);
        beats(1'b1, 1);
        chk("t1_busy_after_last", 32'(busy), 32'd0);
        chk("t1_owner_kept", 32'(owner), 32'd1);

        // 2: simultaneous requests right after reset
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        s0_araddr = 32'h0000_0200; s0_arlen = 5'd2; s0_arid = 4'd1; s0_arvalid = 1'b1;
        s1_araddr = 32'h0000_0300; s1_arlen = 5'd3; s1_arid = 4'd2; s1_arvalid = 1'b1;
        tick;
        ar_accept(1'b0, 32'h0000_0200, 5'd2, 4'd1);
        s0_arvalid = 1'b0;
        chk("t2_s1_pending_arready", 32'(s1_arready), 32'd0);
        beats(1'b0, 2);
        chk("t2_turnaround_busy", 32'(busy), 32'd0);
        chk("t2_turnaround_arvalid", 32'(m_arvalid), 32'd0);
        tick;
        ar_accept(1'b1, 32'h0000_0300, 5'd3, 4'd2);
        s1_arvalid = 1'b0;
        beats(1'b1, 3);
        chk("t2_end_busy", 32'(busy), 32'd0);

        // 3: s1 back-to-back while s0 waits -> s1, s0, s1
        s1_araddr = 32'h0000_0400; s1_arlen = 5'd1; s1_arid = 4'd4; s1_arvalid = 1'b1;
        tick;
        s0_araddr = 32'h0000_0500; s0_arlen = 5'd1; s0_arid = 4'd5; s0_arvalid = 1'b1;
        ar_accept(1'b1, 32'h0000_0400, 5'd1, 4'd4);
        s1_araddr = 32'h0000_0410; s1_arid = 4'd6;
        beats(1'b1, 1);
        tick;
        ar_accept(1'b0, 32'h0000_0500, 5'd1, 4'd5);
        s0_arvalid = 1'b0;
        beats(1'b0, 1);
        tick;
        ar_accept(1'b1, 32'h0000_0410, 5'd1, 4'd6);
        s1_araddr = 32'h0000_0420; s1_arlen = 5'd0; s1_arid = 4'd7;
        beats(1'b1, 1);
        tick;
        // ARLEN=0 is forwarded as-is but moves exactly one beat
        ar_accept(1'b1, 32'h0000_0420, 5'd0, 4'd7);
        s1_arvalid = 1'b0;
        beats(1'b1, 1);
        chk("t3_len0_done", 32'(busy), 32'd0);

        // 4: memory stalls three cycles, then owner back-pressures two cycles
        s0_araddr = 32'h0000_0700; s0_arlen = 5'd4; s0_arid = 4'd8; s0_arvalid = 1'b1;
        tick;
        ar_accept(1'b0, 32'h0000_0700, 5'd4, 4'd8);
        s0_arvalid = 1'b0;
        beats(1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            m_rvalid = 1'b0;
            #1;
            chk("t4_gap_rvalid", 32'(s0_rvalid), 32'd0);
            chk("t4_gap_busy", 32'(busy), 32'd1);
            tick;
        end
        for (int i = 0; i < 2; i++) begin
            m_rvalid = 1'b1;
            s0_rready = 1'b0;
            #1;
            chk("t4_bp_m_rready", 32'(m_rready), 32'd0);
            chk("t4_bp_rvalid", 32'(s0_rvalid), 32'd1);
            tick;
        end
        beats(1'b0, 2);
        chk("t4_busy_before_last", 32'(busy), 32'd1);
        beats(1'b0, 1);
        chk("t4_busy_after_last", 32'(busy), 32'd0);

        // 5: stray beat while IDLE
        chk("t5_proto_err_pre", 32'(proto_err), 32'd0);
        m_rvalid = 1'b1;
        #1;
        chk("t5_s0_rvalid", 32'(s0_rvalid), 32'd0);
        chk("t5_s1_rvalid", 32'(s1_rvalid), 32'd0);
        chk("t5_m_rready", 32'(m_rready), 32'd1);
        tick;
        m_rvalid = 1'b0;
        chk("t5_proto_err_set", 32'(proto_err), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        tick;
        tick;
        chk("t5_proto_err_sticky", 32'(proto_err), 32'd1);

        // 6: reset in the middle of a 4-beat burst
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("t6_proto_err_cleared", 32'(proto_err), 32'd0);
        s1_araddr = 32'h0000_0800; s1_arlen = 5'd4; s1_arid = 4'd9; s1_arvalid = 1'b1;
        tick;
        ar_accept(1'b1, 32'h0000_0800, 5'd4, 4'd9);
        s1_arvalid = 1'b0;
        beats(1'b1, 2);
        rst_n = 1'b0;
        tick;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_arvalid", 32'(m_arvalid), 32'd0);
        chk("t6_owner", 32'(owner), 32'd0);
        rst_n = 1'b1;
        s0_araddr = 32'h0000_0900; s0_arlen = 5'd1; s0_arid = 4'd10; s0_arvalid = 1'b1;
        tick;
        ar_accept(1'b0, 32'h0000_0900, 5'd1, 4'd10);
        s0_arvalid = 1'b0;
        beats(1'b0, 1);
        chk("t6_fresh_done", 32'(busy), 32'd0);
        chk("t6_no_proto_err", 32'(proto_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
